bp_table_update_ctrl: RTL and testbench
=======================================

// Module: bp_table_update_ctrl
// PURPOSE
//  Sequences all writes into the single-ported branch predictor tables (BHT / choice / global / local PHT / LHT).
//  - Sweeps every entry to the initial counter after reset or flush.
//  - Buffers resolved-branch updates from commit and issues them when the frontend lookup leaves the port idle.
//  - Sits between the controller/commit stage and the predictor tables selected by BranchPredictorImpl.
// PARAMETERS
//  NR_ENTRIES   1024   entries per table (power of 2, >=2); IDX_W = $clog2(NR_ENTRIES)
//  QUEUE_DEPTH  4      update queue depth (power of 2, >=2)
//  VLEN         64     PC width
//  INIT_CTR     2'b01  counter value written during sweep (weakly not-taken)
// PORTS
//  clk_i           in   1      clock
//  rst_ni          in   1      synchronous reset, active-low
//  flush_bp_i      in   1      restart table sweep, discard queued updates
//  lookup_valid_i  in   1      frontend reads tables this cycle; write port unavailable
//  upd_valid_i     in   1      resolved branch update (no backpressure)
//  upd_pc_i        in   VLEN   branch PC
//  upd_taken_i     in   1      resolved direction
//  init_busy_o     out  1      sweep in progress; frontend predicts not-taken
//  wr_valid_o      out  1      table write this cycle
//  wr_init_o       out  1      1: force INIT_CTR at wr_idx_o; 0: saturating update
//  wr_idx_o        out  IDX_W  table index
//  wr_taken_o      out  1      update direction (0 when wr_init_o)
//  upd_drop_o      out  1      incoming update dropped this cycle (queue full)
// BEHAVIOUR
//  - Reset (rst_ni low at posedge): state=INIT, sweep idx=0, queue empty.
//    Reset output values: wr_valid_o/wr_init_o/wr_taken_o/upd_drop_o=0, wr_idx_o=0, init_busy_o=1.
//  - All wr_* outputs are registered.
//  - INIT: each cycle issues wr_valid_o=1, wr_init_o=1, wr_idx_o=idx, idx++ (ignores lookup_valid_i).
//    Last write at idx=NR_ENTRIES-1, then ->RUN.
//    init_busy_o is high for exactly NR_ENTRIES cycles after reset release.
//  - INIT: incoming updates are discarded silently; upd_drop_o=0.
//  - RUN: if the queue is non-empty and lookup_valid_i=0, pop the head.
//    Next cycle: wr_valid_o=1, wr_init_o=0, wr_idx_o=head.idx, wr_taken_o=head.taken. Max one write per cycle.
//  - Index = upd_pc_i[IDX_W:1] (RVC-aligned); wraps modulo NR_ENTRIES.
//  - Push: upd_valid_i in RUN enqueues {idx, taken}.
//    Queue full and no pop in the same cycle -> entry dropped, upd_drop_o=1 next cycle.
//    Full with a pop in the same cycle -> push accepted.
//  - Empty queue with a push in the same cycle: the entry is not popped that cycle (min update latency 2 cycles).
//  - flush_bp_i (any state, priority over everything except reset):
//    queue cleared, idx=0, ->INIT, init_busy_o=1 next cycle. Flush mid-sweep restarts at 0.
//  - Stores: lookup_valid_i held high stalls the queue indefinitely; order is preserved (FIFO).
// CONFIGURATION
//  - BP_UPDATE_STATS_EN defined: adds outputs drop_cnt_o[31:0] (dropped updates) and stall_cnt_o[31:0]
//    (cycles with queue non-empty and lookup_valid_i=1). Both saturate at 2^32-1.
//    Both counters clear on reset only, not on flush.
//  - BP_UPDATE_STATS_EN undefined: no counters and no such ports; behaviour otherwise identical.
// STRUCTURE
//  - Package bp_ctrl_pkg: bp_ctrl_state_e {INIT, RUN}; bp_upd_t {idx, taken} parameterised via IDX_W localparam.
//  - Sub-module bp_upd_queue: circular FIFO with ptr wrap, full/empty, clear input.
//  - FSM, sweep counter and write mux live in the top module.
// TESTING
//  1 Reset release, lookup_valid_i=0 -> 1024 writes, wr_init_o=1, idx 0..1023 consecutive;
//    init_busy_o falls after cycle 1024.
//  2 RUN, update pc=0x8000_0046 taken=1 -> 2 cycles later wr_valid_o=1, wr_init_o=0, wr_idx_o=0x023, wr_taken_o=1.
//  3 Queue 3 updates while lookup_valid_i=1 for 10 cycles -> no writes;
//    on release, 3 writes in consecutive cycles, in push order.
//  4 5 updates back-to-back, lookup_valid_i=1, depth 4 -> 5th dropped, upd_drop_o pulses once;
//    with stats, drop_cnt_o=1.
//  5 flush_bp_i at sweep idx=500 with 2 queued updates -> next write idx=0, full 1024-cycle sweep, queued updates never written.
//  6 Push coincident with pop on a full queue -> no drop, all 5 entries written in order.

Source files
------------

// File: rtl/bp_ctrl_pkg.sv
// Package: bp_ctrl_pkg
// Shared types and sizing for the branch predictor table update controller.
// Contents:
//   NR_ENTRIES / IDX_W  - entries per predictor table and the index width
//   QUEUE_DEPTH         - depth of the resolved-branch update queue
//   VLEN                - program counter width
//   INIT_CTR            - counter value the tables write when wr_init_o is set
//   bp_ctrl_state_e     - controller state (sweeping or running)
//   bp_upd_t            - one queued update {idx, taken}
//   pc_to_idx()         - RVC-aligned table index of a branch PC
package bp_ctrl_pkg;

  localparam int NR_ENTRIES  = 1024;
  localparam int IDX_W       = $clog2(NR_ENTRIES);
  localparam int QUEUE_DEPTH = 4;
  localparam int VLEN        = 64;
  localparam logic [1:0] INIT_CTR = 2'b01;

  typedef enum logic {
    INIT,
    RUN
  } bp_ctrl_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } bp_upd_t;

  // Bit 0 is always zero for compressed instructions, so the index starts at bit 1
  // and the upper PC bits fold away (index wraps modulo NR_ENTRIES).
  function automatic logic [IDX_W-1:0] pc_to_idx(input logic [VLEN-1:0] pc);
    return pc[IDX_W:1];
  endfunction

endpackage

// File: rtl/bp_upd_queue.sv
// Module: bp_upd_queue
// Circular FIFO holding resolved-branch updates until the table write port is free.
// Ports:
//   clk, rst_n      - clock and synchronous active-low reset
//   clear           - drop every stored entry (flush)
//   push, push_data - enqueue one entry; caller must not push when full without popping
//   pop             - dequeue the head entry; caller must not pop when empty
//   head            - current head entry (valid when empty is low)
//   empty, full     - occupancy flags
module bp_upd_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  rd_ptr;
  logic [PW:0]  wr_ptr;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal slots
  // with differing wrap bits mean full.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[PW] != wr_ptr[PW]) && (rd_ptr[PW-1:0] == wr_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // On a full queue a simultaneous push lands in the slot being popped; the
  // head is read combinationally before the edge, so the old entry is not lost.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bp_table_update_ctrl.sv
// Module: bp_table_update_ctrl
// Sequences every write into the single-ported branch predictor tables: sweeps all
// entries to INIT_CTR after reset or flush, then drains buffered commit updates
// whenever the frontend lookup leaves the port idle.
// Ports:
//   clk_i, rst_ni   - clock, synchronous active-low reset
//   flush_bp_i      - restart the sweep and discard queued updates
//   lookup_valid_i  - frontend owns the table port this cycle
//   upd_valid_i, upd_pc_i, upd_taken_i - resolved branch update (no backpressure)
//   init_busy_o     - sweep in progress
//   wr_valid_o, wr_init_o, wr_idx_o, wr_taken_o - registered table write
//   upd_drop_o      - an update was dropped on the previous cycle (queue full)
//   drop_cnt_o, stall_cnt_o - only with BP_UPDATE_STATS_EN: saturating counters of
//                     dropped updates and of cycles stalled behind a lookup
module bp_table_update_ctrl
  import bp_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_bp_i,
  input  logic             lookup_valid_i,
  input  logic             upd_valid_i,
  input  logic [VLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  output logic             init_busy_o,
  output logic             wr_valid_o,
  output logic             wr_init_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic             wr_taken_o,
  output logic             upd_drop_o
`ifdef BP_UPDATE_STATS_EN
  ,
  output logic [31:0]      drop_cnt_o,
  output logic [31:0]      stall_cnt_o
`endif
);

  bp_ctrl_state_e   state, state_next;
  logic [IDX_W-1:0] sweep_idx, sweep_idx_next;

  logic             q_push, q_pop, q_empty, q_full;
  bp_upd_t          q_in, q_head;

  logic             wr_valid_next, wr_init_next, wr_taken_next, drop_next;
  logic [IDX_W-1:0] wr_idx_next;

  logic             pc_unused;

  // Only the RVC-aligned index bits of the PC matter to the tables.
  assign pc_unused = ^{upd_pc_i[VLEN-1:IDX_W+1], upd_pc_i[0]};

  assign q_in.idx   = pc_to_idx(upd_pc_i);
  assign q_in.taken = upd_taken_i;

  bp_upd_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     ($bits(bp_upd_t))
  ) u_queue (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clear     (flush_bp_i),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign init_busy_o = (state == INIT);

  // Next-state and write selection. Flush wins over the sweep and over queue
  // traffic; a pop frees a slot so a push on a full queue still fits.
  always_comb begin
    state_next     = state;
    sweep_idx_next = sweep_idx;
    wr_valid_next  = 1'b0;
    wr_init_next   = 1'b0;
    wr_idx_next    = '0;
    wr_taken_next  = 1'b0;
    drop_next      = 1'b0;
    q_push         = 1'b0;
    q_pop          = 1'b0;

    if (flush_bp_i) begin
      state_next     = INIT;
      sweep_idx_next = '0;
    end else begin
      unique case (state)
        INIT: begin
          wr_valid_next  = 1'b1;
          wr_init_next   = 1'b1;
          wr_idx_next    = sweep_idx;
          sweep_idx_next = sweep_idx + 1'b1;
          if (sweep_idx == IDX_W'(NR_ENTRIES - 1)) state_next = RUN;
        end
        RUN: begin
          q_pop = !q_empty && !lookup_valid_i;
          if (q_pop) begin
            wr_valid_next = 1'b1;
            wr_idx_next   = q_head.idx;
            wr_taken_next = q_head.taken;
          end
          if (upd_valid_i) begin
            if (!q_full || q_pop) q_push    = 1'b1;
            else                  drop_next = 1'b1;
          end
        end
        default: state_next = INIT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= INIT;
      sweep_idx  <= '0;
      wr_valid_o <= 1'b0;
      wr_init_o  <= 1'b0;
      wr_idx_o   <= '0;
      wr_taken_o <= 1'b0;
      upd_drop_o <= 1'b0;
    end else begin
      state      <= state_next;
      sweep_idx  <= sweep_idx_next;
      wr_valid_o <= wr_valid_next;
      wr_init_o  <= wr_init_next;
      wr_idx_o   <= wr_idx_next;
      wr_taken_o <= wr_taken_next;
      upd_drop_o <= drop_next;
    end
  end

`ifdef BP_UPDATE_STATS_EN
  // Statistics survive flushes so software can read totals across pipeline restarts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (drop_next && (drop_cnt_o != '1))
        drop_cnt_o <= drop_cnt_o + 1'b1;
      if (!q_empty && lookup_valid_i && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_table_update_ctrl.sv
// Testbench: tb_bp_table_update_ctrl
// Drives directed and random stimulus into bp_table_update_ctrl; a reference model
// pushes expected table writes and drop pulses into scoreboards that a separate
// monitor drains on the falling edge whenever the DUT presents them.
module tb_bp_table_update_ctrl;

  localparam int NR    = 1024;
  localparam int DEPTH = 4;

  typedef struct {
    int cyc;
    bit init;
    int idx;
    bit taken;
  } wr_exp_t;

  typedef struct {
    int idx;
    bit taken;
  } upd_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, lookup, upd_valid, upd_taken;
  logic [63:0] upd_pc;
  logic        init_busy, wr_valid, wr_init, wr_taken, upd_drop;
  logic [9:0]  wr_idx;
`ifdef BP_UPDATE_STATS_EN
  logic [31:0] drop_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 0;

  wr_exp_t wr_q[$];
  int      drop_q[$];
  upd_t    mq[$];
  bit      m_init = 1;
  int      m_pos  = 0;
  bit      m_busy = 1;
  int      m_drops = 0;
  int      m_stalls = 0;

  bp_table_update_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_bp_i     (flush),
    .lookup_valid_i (lookup),
    .upd_valid_i    (upd_valid),
    .upd_pc_i       (upd_pc),
    .upd_taken_i    (upd_taken),
    .init_busy_o    (init_busy),
    .wr_valid_o     (wr_valid),
    .wr_init_o      (wr_init),
    .wr_idx_o       (wr_idx),
    .wr_taken_o     (wr_taken),
    .upd_drop_o     (upd_drop)
`ifdef BP_UPDATE_STATS_EN
    ,
    .drop_cnt_o     (drop_cnt),
    .stall_cnt_o    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a sweep position counter and a bounded list of pending
  // updates, stepped once per rising edge with the inputs the DUT just sampled.
  task automatic modelStep();
    upd_t h;
    bit   popping;
    cyc++;
    if (!rst_n) begin
      m_init = 1; m_pos = 0; mq.delete();
      m_drops = 0; m_stalls = 0;
    end else if (flush) begin
      if (mq.size() > 0 && lookup) m_stalls++;
      mq.delete(); m_init = 1; m_pos = 0;
    end else if (m_init) begin
      wr_q.push_back('{cyc, 1'b1, m_pos, 1'b0});
      m_pos++;
      if (m_pos == NR) m_init = 0;
    end else begin
      if (mq.size() > 0 && lookup) m_stalls++;
      popping = (mq.size() > 0) && !lookup;
      if (popping) begin
        h = mq.pop_front();
        wr_q.push_back('{cyc, 1'b0, h.idx, h.taken});
      end
      if (upd_valid) begin
        if (mq.size() < DEPTH) mq.push_back('{int'((upd_pc >> 1) % NR), upd_taken});
        else begin
          drop_q.push_back(cyc);
          m_drops++;
        end
      end
    end
    m_busy = m_init;
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit lk, input bit uv,
                               input logic [63:0] pc, input bit tk);
    rst_n = r; flush = f; lookup = lk; upd_valid = uv; upd_pc = pc; upd_taken = tk;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input int n, input bit lk);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, lk, 0, 64'h0, 0);
  endtask

  // Monitor: pops the scoreboards whenever the DUT shows a write or a drop, and
  // flags expectations whose cycle passed with nothing on the outputs.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("init_busy", init_busy, m_busy);
      if (wr_valid) begin
        if (wr_q.size() == 0) checkOutput("unexpected_write", wr_idx, -1);
        else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          checkOutput("wr_cycle", cyc, e.cyc);
          checkOutput("wr_fields", {wr_init, wr_taken, 22'(wr_idx)}, {e.init, e.taken, 22'(e.idx)});
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        wr_exp_t e;
        e = wr_q.pop_front();
        checkOutput("missing_write", 0, e.cyc);
      end
      if (upd_drop) begin
        if (drop_q.size() == 0) checkOutput("unexpected_drop", cyc, -1);
        else checkOutput("drop_cycle", cyc, drop_q.pop_front());
      end else if (drop_q.size() > 0 && drop_q[0] <= cyc) begin
        checkOutput("missing_drop", 0, drop_q.pop_front());
      end
    end
  end

  initial begin
    logic [63:0] rpc;
    // Reset and its output values
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 64'h0, 0);
    started = 1;
    checkOutput("reset_outputs", {wr_valid, wr_init, wr_taken, upd_drop, init_busy, wr_idx},
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0});

    // Full sweep after reset release
    idle(NR, 0);
    idle(3, 0);
    checkOutput("busy_after_sweep", init_busy, 0);

    // Single update, two-cycle latency, index from PC bits [10:1]
    applyStimulus(1, 0, 0, 1, 64'h0000_0000_8000_0046, 1);
    idle(4, 0);

    // Three updates held off by lookups, then drained in order
    applyStimulus(1, 0, 1, 1, 64'h10, 1);
    applyStimulus(1, 0, 1, 1, 64'h22, 0);
    applyStimulus(1, 0, 1, 1, 64'h7fe, 1);
    idle(7, 1);
    idle(6, 0);

    // Five back-to-back updates into a depth-4 queue: one drop
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1, 64'(i * 6 + 2), i[0]);
    idle(8, 0);

    // Push coincident with pop on a full queue: no drop
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 1, 64'(i * 10 + 100), !i[0]);
    applyStimulus(1, 0, 0, 1, 64'h3ff, 1);
    idle(8, 0);

    // Flush with queued updates, flush again mid-sweep at index 500
    applyStimulus(1, 0, 1, 1, 64'h40, 1);
    applyStimulus(1, 0, 1, 1, 64'h42, 1);
    applyStimulus(1, 1, 1, 0, 64'h0, 0);
    idle(500, 0);
    applyStimulus(1, 1, 0, 0, 64'h0, 0);
    idle(NR + 4, 0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      rpc = {$urandom, $urandom};
      applyStimulus(1, ($urandom_range(0, 799) == 0), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 2) != 0), rpc, $urandom_range(0, 1) == 1);
    end
    idle(NR + 10, 0);

    checkOutput("write_scoreboard_drained", wr_q.size(), 0);
    checkOutput("drop_scoreboard_drained", drop_q.size(), 0);
`ifdef BP_UPDATE_STATS_EN
    checkOutput("drop_cnt", drop_cnt, m_drops);
    checkOutput("stall_cnt", stall_cnt, m_stalls);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
